fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//   Round-robin arbiter that shares the single write port of the byte FIFO between
//   NUM_REQ producers. Grants one producer at a time and forwards its data to the
//   FIFO buf_in/wr_en pins. Stalls on FIFO full. Caps each grant at MAX_BURST words
//   so that no producer can starve the others.
// PARAMETERS
//   NUM_REQ    4   number of producers (>=2)
//   DATA_W     8   word width; matches the FIFO buf_in width
//   MAX_BURST  4   maximum words written per grant (>=1)
// PORTS
//   clk        in   1                rising-edge clock
//   rst        in   1                synchronous, active-high reset
//   req        in   NUM_REQ          req[i]=1: producer i has a valid word on its data slice
//   req_data   in   NUM_REQ*DATA_W   producer i data on bits [i*DATA_W +: DATA_W]
//   fifo_full  in   1                FIFO full flag
//   gnt        out  NUM_REQ          one-hot registered grant; all zero when idle
//   ack        out  NUM_REQ          ack[i]=1: producer i word written this cycle
//   fifo_wr_en out  1                drives FIFO wr_en
//   fifo_din   out  DATA_W           drives FIFO buf_in
//   busy       out  1                1 while in BURST state
// BEHAVIOUR
//   Reset (rst=1 at a clk edge):
//     state=IDLE, gnt=0, rr_ptr=0, burst_cnt=0.
//     While rst=1, fifo_wr_en=0 and ack=0 regardless of state.
//   Reset mid-burst:
//     The word presented in the rst cycle is not written.
//     Arbitration restarts from producer 0.
//   FSM, two states:
//     IDLE:
//       If any req, pick the first set req[k] searching k=rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//       Next cycle: gnt=onehot(k), owner=k, burst_cnt=0, state=BURST.
//       No write happens in IDLE, so each grant costs a 1-cycle arbitration bubble.
//     BURST:
//       write = req[owner] & ~fifo_full & ~rst.
//       fifo_wr_en = write. ack[owner] = write. fifo_din = req_data slice of owner.
//       All three are combinational from registered state.
//       fifo_din is don't-care when write=0; it is driven 0 in IDLE.
//       On write: burst_cnt+1.
//       If write and burst_cnt==MAX_BURST-1: release.
//       If req[owner]=0: release immediately, with no write.
//       fifo_full=1 with req[owner]=1: hold grant, burst_cnt unchanged, no write.
//       Release means: next cycle state=IDLE, gnt=0, rr_ptr=(owner+1) mod NUM_REQ.
//   Counter width: burst_cnt is $clog2(MAX_BURST+1) bits. It never exceeds MAX_BURST-1.
//   Producer contract:
//     Hold req_data stable while req=1 and ack=0.
//     May drop req at any time; a drop ends the grant.
//     ack is the only indication that a word was consumed.
//   Requests arriving during BURST are not seen until the next IDLE cycle.
//     A release with no other requester regrants the same producer after the bubble.
//   busy = (state==BURST). gnt is never more than one-hot.
// TESTING  (NUM_REQ=4, DATA_W=8, MAX_BURST=4, FIFO 8 deep)
//   1. Only req[1] high for 6 words 8'h11..8'h16
//      -> gnt=4'b0010 one cycle after req.
//      -> 4 consecutive writes 11-14, gnt=0 for 1 cycle.
//      -> regrant 0010, writes 15-16.
//   2. req=4'b1111 held
//      -> grant order 0,1,2,3,0, each with 4 writes.
//      -> exactly 1 idle cycle between grants.
//   3. fifo_full=1 for 3 cycles after the 2nd word of a burst
//      -> fifo_wr_en=0 and gnt held for those cycles.
//      -> then 2 more writes; 4 words total.
//   4. Producer 2 drops req after 2 acks while req[3] is high
//      -> release, bubble, gnt=4'b1000.
//   5. rst pulsed during a burst of producer 3
//      -> fifo_wr_en=0 in the rst cycle, gnt=0 next.
//      -> with req=4'b1001, producer 0 is granted first.
//   6. Integration: 4 producers write 8 words into the FIFO
//      -> full=1; no extra write issued.
//      -> FIFO readout matches ack order.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers.
// Each grant is capped at MAX_BURST words and is followed by a one-cycle IDLE bubble.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      fifo_full,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_din,
  output logic                      busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state, state_n;
  logic [NUM_REQ-1:0] gnt_n;
  logic [PTR_W-1:0]   owner, owner_n;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_n;
  logic [PTR_W-1:0]   pick, cand, owner_inc;
  logic [CNT_W-1:0]   burst_cnt, burst_cnt_n;
  logic               found;
  logic               write;

  // First requester at or after rr_ptr, wrapping around.
  always_comb begin
    pick  = rr_ptr;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign owner_inc  = (owner == LAST_IDX) ? '0 : owner + 1'b1;
  assign write      = (state == BURST) && req[owner] && !fifo_full && !rst;
  assign fifo_wr_en = write;
  assign busy       = (state == BURST);

  always_comb begin
    ack        = '0;
    ack[owner] = write;
    fifo_din   = '0;
    if (state == BURST) begin
      fifo_din = req_data[int'(owner)*DATA_W +: DATA_W];
    end
  end

  // A dropped request or the last word of a burst both release the grant.
  always_comb begin
    state_n     = state;
    gnt_n       = gnt;
    owner_n     = owner;
    rr_ptr_n    = rr_ptr;
    burst_cnt_n = burst_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          state_n     = BURST;
          gnt_n       = '0;
          gnt_n[pick] = 1'b1;
          owner_n     = pick;
          burst_cnt_n = '0;
        end
      end
      BURST: begin
        if (!req[owner] || (write && burst_cnt == LAST_CNT)) begin
          state_n     = IDLE;
          gnt_n       = '0;
          rr_ptr_n    = owner_inc;
          burst_cnt_n = '0;
        end else if (write) begin
          burst_cnt_n = burst_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      owner     <= owner_n;
      rr_ptr    <= rr_ptr_n;
      burst_cnt <= burst_cnt_n;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed producer streams with hand-computed
// write order and grant sequence, plus an 8-deep FIFO model for the integration case.
module tb_fifo_wr_arbiter;

  localparam int NR     = 4;
  localparam int DW     = 8;
  localparam int FDEPTH = 8;

  logic          clk;
  logic          rst;
  logic [NR-1:0] req;
  logic [NR*DW-1:0] req_data;
  logic          fifo_full;
  logic [NR-1:0] gnt;
  logic [NR-1:0] ack;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_din;
  logic          busy;

  typedef struct packed { logic [1:0] prod; logic [7:0] data; } wr_t;
  typedef struct { logic [3:0] g; int gap; int writes; } gr_t;

  wr_t sb[$];
  gr_t gq[$];
  int  errors = 0;
  int  checks = 0;

  logic [7:0] pw[NR][32];
  int         ph[NR];
  int         pt[NR];

  logic [NR-1:0] ack_seen = '0;
  logic          wr_seen = 1'b0;
  logic [7:0]    din_seen = '0;
  logic          full_force = 1'b0;
  logic          integ = 1'b0;
  int            fcount = 0;
  logic [7:0]    fmem[FDEPTH];
  logic [7:0]    ack_log[$];

  logic [3:0] prev_gnt = '0;
  int         gap_cnt = 0;
  int         wr_cnt = 0;
  int         cur_exp_writes = -1;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .fifo_full(fifo_full),
    .gnt(gnt), .ack(ack), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void refreshReq();
    for (int i = 0; i < NR; i++) begin
      req[i] = (ph[i] < pt[i]);
      req_data[i*DW +: DW] = (ph[i] < pt[i]) ? pw[i][ph[i]] : 8'h00;
    end
  endfunction

  task automatic applyStimulus(input int p, input logic [7:0] first, input int n);
    for (int k = 0; k < n; k++) begin
      pw[p][pt[p]] = first + 8'(k);
      pt[p]++;
    end
    refreshReq();
  endtask

  task automatic expectWrite(input int p, input logic [7:0] d);
    sb.push_back('{prod: 2'(p), data: d});
  endtask

  task automatic expectGrant(input logic [3:0] g, input int gap, input int w);
    gq.push_back('{g: g, gap: gap, writes: w});
  endtask

  // Producers consume on the ack seen before this edge; the FIFO model stores likewise.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (ack_seen[i] && ph[i] < pt[i]) begin
        ack_log.push_back(pw[i][ph[i]]);
        ph[i]++;
      end
    end
    if (integ && wr_seen) begin
      if (fcount < FDEPTH) fmem[fcount] = din_seen;
      fcount++;
    end
    fifo_full = integ ? (fcount >= FDEPTH) : full_force;
    refreshReq();
  endtask

  task automatic applyReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < NR; i++) begin
      ph[i] = 0;
      pt[i] = 0;
    end
    refreshReq();
  endtask

  task automatic waitIdle(input string name, input int budget);
    int n = 0;
    while (n < budget && !(sb.size() == 0 && gq.size() == 0 && gnt == 0 && req == 0)) begin
      tick();
      n++;
    end
    checkOutput({name, " drained"}, 32'(n < budget), 32'd1);
    tick();
    tick();
  endtask

  // Monitor: pops the write scoreboard on every write and the grant queue on every new grant.
  always @(negedge clk) begin : monitor
    wr_t e;
    gr_t r;
    ack_seen = ack;
    wr_seen  = fifo_wr_en;
    din_seen = fifo_din;
    if (gnt != 0 && prev_gnt == 0) begin
      if (gq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected grant: got %b expected none", gnt);
        cur_exp_writes = -1;
      end else begin
        r = gq.pop_front();
        checkOutput("grant", 32'(gnt), 32'(r.g));
        if (r.gap >= 0) checkOutput("grant gap", gap_cnt, r.gap);
        cur_exp_writes = r.writes;
      end
      gap_cnt = 0;
      wr_cnt  = 0;
    end
    if (fifo_wr_en) begin
      wr_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected write: got din=%h ack=%b expected no write", fifo_din, ack);
      end else begin
        e = sb.pop_front();
        checkOutput("write data", 32'(fifo_din), 32'(e.data));
        checkOutput("write ack", 32'(ack), 32'(4'b0001 << e.prod));
      end
    end
    if (gnt == 0 && prev_gnt != 0 && cur_exp_writes >= 0)
      checkOutput("burst writes", wr_cnt, cur_exp_writes);
    if (gnt == 0) gap_cnt++;
    prev_gnt = gnt;
  end

  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    req = '0;
    req_data = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < NR; i++) begin
      ph[i] = 0;
      pt[i] = 0;
    end
    tick();
    tick();
    @(negedge clk);
    checkOutput("reset gnt", 32'(gnt), 32'd0);
    checkOutput("reset ack", 32'(ack), 32'd0);
    checkOutput("reset wr_en", 32'(fifo_wr_en), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset din", 32'(fifo_din), 32'd0);
    rst = 1'b0;

    $display("[TB] single producer, 6 words");
    applyStimulus(1, 8'h11, 6);
    for (int k = 0; k < 6; k++) expectWrite(1, 8'h11 + 8'(k));
    expectGrant(4'b0010, -1, 4);
    expectGrant(4'b0010, 1, 2);
    tick();
    @(negedge clk);
    checkOutput("t1 gnt after req", 32'(gnt), 32'b0010);
    checkOutput("t1 busy", 32'(busy), 32'd1);
    waitIdle("t1", 60);

    $display("[TB] all producers requesting");
    applyReset();
    applyStimulus(0, 8'h20, 4);
    applyStimulus(1, 8'h24, 4);
    applyStimulus(2, 8'h28, 4);
    applyStimulus(3, 8'h2C, 4);
    applyStimulus(0, 8'h40, 4);
    for (int k = 0; k < 16; k++) expectWrite(k / 4, 8'h20 + 8'(k));
    for (int k = 0; k < 4; k++) expectWrite(0, 8'h40 + 8'(k));
    expectGrant(4'b0001, -1, 4);
    expectGrant(4'b0010, 1, 4);
    expectGrant(4'b0100, 1, 4);
    expectGrant(4'b1000, 1, 4);
    expectGrant(4'b0001, 1, 4);
    waitIdle("t2", 150);

    $display("[TB] fifo full stall mid-burst");
    applyReset();
    applyStimulus(0, 8'h30, 4);
    for (int k = 0; k < 4; k++) expectWrite(0, 8'h30 + 8'(k));
    expectGrant(4'b0001, -1, 4);
    tick();
    tick();
    tick();
    full_force = 1'b1;
    fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("t3 stall wr_en", 32'(fifo_wr_en), 32'd0);
      checkOutput("t3 stall gnt", 32'(gnt), 32'b0001);
      tick();
    end
    full_force = 1'b0;
    fifo_full = 1'b0;
    waitIdle("t3", 40);

    $display("[TB] producer drops request");
    applyReset();
    applyStimulus(2, 8'h50, 2);
    applyStimulus(3, 8'h60, 1);
    expectWrite(2, 8'h50);
    expectWrite(2, 8'h51);
    expectWrite(3, 8'h60);
    expectGrant(4'b0100, -1, 2);
    expectGrant(4'b1000, 1, 1);
    waitIdle("t4", 40);

    $display("[TB] reset during burst");
    applyReset();
    applyStimulus(3, 8'h70, 4);
    expectWrite(3, 8'h70);
    expectWrite(0, 8'h80);
    expectWrite(0, 8'h81);
    expectWrite(3, 8'h71);
    expectWrite(3, 8'h72);
    expectWrite(3, 8'h73);
    expectGrant(4'b1000, -1, 1);
    expectGrant(4'b0001, -1, 2);
    expectGrant(4'b1000, 1, 3);
    tick();
    tick();
    rst = 1'b1;
    applyStimulus(0, 8'h80, 2);
    @(negedge clk);
    checkOutput("t5 rst wr_en", 32'(fifo_wr_en), 32'd0);
    checkOutput("t5 rst ack", 32'(ack), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t5 gnt after rst", 32'(gnt), 32'd0);
    checkOutput("t5 busy after rst", 32'(busy), 32'd0);
    waitIdle("t5", 60);

    $display("[TB] integration with 8-deep fifo");
    applyReset();
    integ = 1'b1;
    fcount = 0;
    ack_log.delete();
    fifo_full = 1'b0;
    applyStimulus(0, 8'h90, 3);
    applyStimulus(1, 8'hA0, 3);
    applyStimulus(2, 8'hB0, 3);
    applyStimulus(3, 8'hC0, 3);
    for (int k = 0; k < 3; k++) expectWrite(0, 8'h90 + 8'(k));
    for (int k = 0; k < 3; k++) expectWrite(1, 8'hA0 + 8'(k));
    expectWrite(2, 8'hB0);
    expectWrite(2, 8'hB1);
    expectGrant(4'b0001, -1, 3);
    expectGrant(4'b0010, 1, 3);
    expectGrant(4'b0100, 1, -1);
    n = 0;
    while (n < 100 && fcount < FDEPTH) begin
      tick();
      n++;
    end
    checkOutput("t6 filled in time", 32'(n < 100), 32'd1);
    repeat (10) tick();
    @(negedge clk);
    checkOutput("t6 fifo count", fcount, FDEPTH);
    checkOutput("t6 full", 32'(fifo_full), 32'd1);
    checkOutput("t6 no write when full", 32'(fifo_wr_en), 32'd0);
    checkOutput("t6 grant held", 32'(gnt), 32'b0100);
    checkOutput("t6 scoreboard empty", sb.size(), 0);
    checkOutput("t6 grants consumed", gq.size(), 0);
    checkOutput("t6 ack count", ack_log.size(), FDEPTH);
    for (int i = 0; i < FDEPTH && i < ack_log.size(); i++)
      checkOutput($sformatf("t6 readout %0d", i), 32'(fmem[i]), 32'(ack_log[i]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
